soc_l2_bank_arbiter: RTL
========================

Name: soc_l2_bank_arbiter

Overview:
Shares one L2 SRAM bank port between NR_MASTERS TCDM requesters, such as FC data, uDMA TX/RX and AXI-bridge lanes. It sits between the interleaved-crossbar outputs and a single bank macro. Arbitration is round-robin with an optional bounded-priority master 0. Each response is routed back to the requester granted one cycle earlier. A saturating contention counter and a sticky protocol-error flag are exposed for debug.

Parameters:
NR_MASTERS, 4, number of requesters (2..8)
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
HI_PRIO_EN, 1, 1: master 0 has priority; 0: pure round-robin
MAX_HI_PRIO_GRANTS, 4, max consecutive master-0 grants while others wait (>=1)
CNT_WIDTH, 16, contention counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  NR_MASTERS  per-master request
add_i  in  NR_MASTERS*ADDR_WIDTH  packed addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wen_i  in  NR_MASTERS  1=read, 0=write
wdata_i  in  NR_MASTERS*DATA_WIDTH  packed write data
be_i  in  NR_MASTERS*DATA_WIDTH/8  packed byte enables
gnt_o  out  NR_MASTERS  per-master grant
r_valid_o  out  NR_MASTERS  per-master response valid
r_rdata_o  out  DATA_WIDTH  response data, shared by all masters
bank_req_o  out  1  bank request
bank_add_o  out  ADDR_WIDTH  bank address
bank_wen_o  out  1  bank write-enable, active-low
bank_wdata_o  out  DATA_WIDTH  bank write data
bank_be_o  out  DATA_WIDTH/8  bank byte enables
bank_gnt_i  in  1  bank grant
bank_r_valid_i  in  1  bank response, exactly 1 cycle after a handshake
bank_r_rdata_i  in  DATA_WIDTH  bank read data
conflict_cnt_o  out  CNT_WIDTH  saturating count of contention cycles
err_o  out  1  sticky protocol error
clr_stats_i  in  1  clears conflict_cnt_o and err_o

Behaviour:
- Reset: rr_ptr=0, hp_cnt=0, resp_vld=0, resp_idx=0, conflict_cnt_o=0, err_o=0.
- Reset values of outputs: r_valid_o=0. gnt_o and bank_* are combinational and follow the req_i=0 value: all 0, except bank_wen_o=1.
- Selection is combinational, same cycle. bank_req_o = |req_i. bank_add_o/wen/wdata/be are muxed from the selected master sel.
- gnt_o[sel] = bank_gnt_i & req_i[sel]. All other gnt_o bits are 0. The req-to-gnt path is combinational, as TCDM requires.
- Round-robin: sel is the first requesting index at or after rr_ptr, wrapping modulo NR_MASTERS. On a handshake (bank_req_o & bank_gnt_i), rr_ptr <= (sel+1) mod NR_MASTERS.
- Priority (HI_PRIO_EN=1): sel=0 if req_i[0] and hp_cnt<MAX_HI_PRIO_GRANTS.
  - On a master-0 handshake while any other req_i bit is set: hp_cnt++.
  - On a master-0 handshake with no other requester: hp_cnt=0.
  - On a handshake to any other master: hp_cnt=0.
  - When hp_cnt==MAX, master 0 loses priority and plain round-robin selects; rr_ptr still advances.
- Withdrawing a request before grant is legal. Selection is recomputed every cycle and no state is held.
- Response path: on handshake, resp_vld<=1 and resp_idx<=sel; otherwise resp_vld<=0.
  - r_valid_o[resp_idx] = resp_vld & bank_r_valid_i.
  - r_rdata_o = bank_r_rdata_i, passed through.
  - Back-to-back handshakes give back-to-back responses, full throughput of 1 per cycle.
- Errors: bank_r_valid_i with resp_vld=0, or resp_vld=1 without bank_r_valid_i, sets err_o. The stray response is dropped; all r_valid_o stay 0.
- conflict_cnt_o: +1 on each cycle with >=2 req_i bits set. It saturates at all-ones.
- clr_stats_i: clears the counter and err_o. If clr_stats_i coincides with an increment or error event, the clear wins.
- Reset mid-transaction: a pending resp_vld is discarded, and no r_valid_o is issued the cycle after reset.

Test Plan:
- Round-robin: NR_MASTERS=4, HI_PRIO_EN=0, req_i=4'b1111, bank_gnt_i=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3. conflict_cnt_o=8.
- Priority bound: HI_PRIO_EN=1, MAX=4, req_i[0] and req_i[2] held high -> grants 0,0,0,0,2,0,0,0,0,2.
- Bank stall: req_i=4'b0110, bank_gnt_i=0 for 3 cycles then 1 -> gnt_o=0 while stalled, then gnt_o=4'b0010 on release. rr_ptr does not move during the stall.
- Response routing: master 3 reads 0x1C01_0000 and the bank returns 0xDEADBEEF next cycle -> r_valid_o=4'b1000, r_rdata_o=0xDEADBEEF. Back-to-back reads by masters 1 then 2 -> r_valid_o 0010 then 0100 on consecutive cycles.
- Error: bank_r_valid_i pulsed with no prior handshake -> r_valid_o=0, err_o=1 and held. clr_stats_i pulse -> err_o=0.
- Reset: rst_i asserted on the cycle after a handshake -> no r_valid_o; rr_ptr=0, so the next req_i=4'b1111 grants master 0 first. With CNT_WIDTH=4 and 20 conflict cycles, conflict_cnt_o=15.

Source files
------------

// File: rtl/soc_l2_bank_arbiter.sv
// Shares one L2 SRAM bank port among NR_MASTERS TCDM requesters.
// Round-robin arbitration, optional bounded priority for master 0, and one-cycle response routing.
module soc_l2_bank_arbiter #(
    parameter int NR_MASTERS         = 4,
    parameter int ADDR_WIDTH         = 32,
    parameter int DATA_WIDTH         = 32,
    parameter int HI_PRIO_EN         = 1,
    parameter int MAX_HI_PRIO_GRANTS = 4,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NR_MASTERS-1:0]               req_i,
    input  logic [NR_MASTERS*ADDR_WIDTH-1:0]    add_i,
    input  logic [NR_MASTERS-1:0]               wen_i,
    input  logic [NR_MASTERS*DATA_WIDTH-1:0]    wdata_i,
    input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]  be_i,
    output logic [NR_MASTERS-1:0]               gnt_o,
    output logic [NR_MASTERS-1:0]               r_valid_o,
    output logic [DATA_WIDTH-1:0]               r_rdata_o,
    output logic                                bank_req_o,
    output logic [ADDR_WIDTH-1:0]               bank_add_o,
    output logic                                bank_wen_o,
    output logic [DATA_WIDTH-1:0]               bank_wdata_o,
    output logic [DATA_WIDTH/8-1:0]             bank_be_o,
    input  logic                                bank_gnt_i,
    input  logic                                bank_r_valid_i,
    input  logic [DATA_WIDTH-1:0]               bank_r_rdata_i,
    output logic [CNT_WIDTH-1:0]                conflict_cnt_o,
    output logic                                err_o,
    input  logic                                clr_stats_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W    = $clog2(NR_MASTERS);
    localparam int HP_W     = $clog2(MAX_HI_PRIO_GRANTS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NR_MASTERS - 1);
    localparam logic [IDX_W:0]   NR_WIDE  = (IDX_W+1)'(NR_MASTERS);
    localparam logic [HP_W-1:0]  HP_MAX   = HP_W'(MAX_HI_PRIO_GRANTS);

    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [HP_W-1:0]      hp_cnt_q, hp_cnt_d;
    logic                 resp_vld_q, resp_vld_d;
    logic [IDX_W-1:0]     resp_idx_q, resp_idx_d;
    logic [CNT_WIDTH-1:0] conflict_cnt_q, conflict_cnt_d;
    logic                 err_q, err_d;

    logic [IDX_W-1:0]     rr_sel, sel;
    logic [IDX_W:0]       idx_wide;
    logic                 rr_found, hp_win, handshake, others_req, conflict, err_event, resp_ok;

    logic [ADDR_WIDTH-1:0] add_arr   [NR_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NR_MASTERS];
    logic [BE_WIDTH-1:0]   be_arr    [NR_MASTERS];

    generate
        for (genvar gi = 0; gi < NR_MASTERS; gi++) begin : g_master
            assign add_arr[gi]   = add_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign be_arr[gi]    = be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign gnt_o[gi]     = (sel == IDX_W'(gi)) & req_i[gi] & bank_gnt_i;
            assign r_valid_o[gi] = resp_ok & (resp_idx_q == IDX_W'(gi));
        end
    endgenerate

    // First requester at or after rr_ptr, wrapping without a modulo operator.
    always_comb begin
        rr_sel   = rr_ptr_q;
        rr_found = 1'b0;
        idx_wide = '0;
        for (int k = 0; k < NR_MASTERS; k++) begin
            idx_wide = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (idx_wide >= NR_WIDE) begin
                idx_wide = idx_wide - NR_WIDE;
            end
            if (!rr_found && req_i[idx_wide[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = idx_wide[IDX_W-1:0];
            end
        end
    end

    assign hp_win     = (HI_PRIO_EN != 0) && req_i[0] && (hp_cnt_q < HP_MAX);
    assign sel        = hp_win ? '0 : rr_sel;
    assign bank_req_o = |req_i;
    assign handshake  = bank_req_o & bank_gnt_i;
    assign others_req = |req_i[NR_MASTERS-1:1];
    assign conflict   = |(req_i & (req_i - NR_MASTERS'(1)));
    assign err_event  = bank_r_valid_i ^ resp_vld_q;

    assign bank_add_o   = bank_req_o ? add_arr[sel]   : '0;
    assign bank_wen_o   = bank_req_o ? wen_i[sel]     : 1'b1;
    assign bank_wdata_o = bank_req_o ? wdata_arr[sel] : '0;
    assign bank_be_o    = bank_req_o ? be_arr[sel]    : '0;

    // A response landing in a reset cycle belongs to a discarded transaction.
    assign resp_ok        = resp_vld_q & bank_r_valid_i & ~rst_i;
    assign r_rdata_o      = bank_r_rdata_i;
    assign conflict_cnt_o = conflict_cnt_q;
    assign err_o          = err_q;

    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        hp_cnt_d       = hp_cnt_q;
        resp_vld_d     = handshake;
        resp_idx_d     = resp_idx_q;
        conflict_cnt_d = conflict_cnt_q;
        err_d          = err_q | err_event;
        if (handshake) begin
            rr_ptr_d   = (sel == LAST_IDX) ? '0 : sel + IDX_W'(1);
            resp_idx_d = sel;
            if ((sel == '0) && others_req) begin
                if (hp_cnt_q != HP_MAX) begin
                    hp_cnt_d = hp_cnt_q + HP_W'(1);
                end
            end else begin
                hp_cnt_d = '0;
            end
        end
        if (conflict && (conflict_cnt_q != {CNT_WIDTH{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CNT_WIDTH'(1);
        end
        if (clr_stats_i) begin
            conflict_cnt_d = '0;
            err_d          = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q       <= '0;
            hp_cnt_q       <= '0;
            resp_vld_q     <= 1'b0;
            resp_idx_q     <= '0;
            conflict_cnt_q <= '0;
            err_q          <= 1'b0;
        end else begin
            rr_ptr_q       <= rr_ptr_d;
            hp_cnt_q       <= hp_cnt_d;
            resp_vld_q     <= resp_vld_d;
            resp_idx_q     <= resp_idx_d;
            conflict_cnt_q <= conflict_cnt_d;
            err_q          <= err_d;
        end
    end

endmodule
